dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
//  Memory-side responder for the M-stage data-memory access port of the pipelined CPU.
//  Accepts one load/store request at a time over a valid/ready handshake.
//  Models a fixed access latency and performs little-endian byte/half/word lane merging.
//  Sign- or zero-extends loads, flags illegal accesses, and emits one store-log beat per committed write.
// PARAMETERS
//  DEPTH_WORDS  4096  number of 32-bit words in the backing array
//  LATENCY      2     cycles from request acceptance to response; legal range 1..15
// PORTS
//  clk           in   1   single clock, rising edge
//  reset         in   1   asynchronous, active-low (0 = reset)
//  req_valid     in   1   request present
//  req_ready     out  1   responder can accept a request this cycle
//  req_we        in   1   1 = store, 0 = load
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  req_width     in   2   00 word, 01 half, 10 byte, 11 illegal
//  req_sign      in   1   load extension: 1 = sign-extend, 0 = zero-extend
//  req_pc        in   32  PC of the issuing instruction, for logging
//  rsp_valid     out  1   one-cycle response pulse
//  rsp_rdata     out  32  load result, already extended; 0 for stores or on error
//  rsp_err       out  1   access was misaligned, out of range, or illegal width
//  log_valid     out  1   committed store this cycle (coincident with rsp_valid)
//  log_pc        out  32  req_pc of the committed store
//  log_addr      out  32  word-aligned address ({addr[31:2],2'b00})
//  log_data      out  32  full merged word after the store
// BEHAVIOUR
//  Reset (reset==0, asynchronous):
//   - state=IDLE; all outputs 0 except req_ready=1.
//   - Backing array cleared to 0; any in-flight request is discarded with no write and no response.
//  FSM states: IDLE, WAIT, RESP.
//   - req_ready=1 in IDLE and RESP; 0 in WAIT.
//   - Accept when req_valid && req_ready. On acceptance, latch all req_* fields and load cnt=LATENCY-1.
//   - On accept, go to RESP if LATENCY==1, otherwise go to WAIT.
//   - In WAIT, cnt decrements each cycle; at cnt==1 the next state is RESP.
//   - RESP lasts exactly 1 cycle. Next state is IDLE, or it restarts if a new request is accepted that cycle.
//  Timing:
//   - Accept at edge T -> rsp_valid high during cycle T+LATENCY.
//   - Peak throughput is one request per LATENCY cycles. There is no response back-pressure.
//  Commit: the array read or write happens on the edge that enters RESP.
//   - A store followed by a load to the same word returns the stored data.
//  Lanes (little-endian):
//   - Byte k=addr[1:0] maps to bits [8k+7:8k].
//   - Half h=addr[1] maps to bits [16h+15:16h].
//   - A store merges only its lanes; the other bytes are unchanged.
//  Load extension:
//   - Byte: bit 7 is replicated when req_sign=1, else zero-filled.
//   - Half: bit 15 is replicated when req_sign=1, else zero-filled.
//   - Word: returned unchanged.
//  Errors: rsp_err=1, no write, rsp_rdata=0, log_valid=0 when any of the following holds:
//   - width 11;
//   - word access with addr[1:0]!=0;
//   - half access with addr[0]!=0;
//   - addr[31:2] >= DEPTH_WORDS.
//  rsp_rdata, rsp_err and log_* are valid only while rsp_valid=1, and are driven 0 otherwise.
//  req_valid while req_ready=0 is ignored. The requester must hold the request until it is accepted.
// TESTING
//  1. Store word 0x12345678 @0x10, then load word @0x10.
//     -> log_valid, log_addr=0x10, log_data=0x12345678; load returns rsp_rdata=0x12345678.
//  2. Store byte 0x80 @0x21, then load byte @0x21 with req_sign=1, then with req_sign=0.
//     -> 0xFFFFFF80, then 0x00000080. Word @0x20 reads 0x00008000.
//  3. Half store @0x03, and word load @0x06.
//     -> rsp_err=1 for both; the word @0x00 is unchanged; log_valid=0.
//  4. LATENCY=2, req_valid held high with 3 requests.
//     -> accepts at T, T+2, T+4; rsp_valid at T+2, T+4, T+6; req_ready low at T+1, T+3, T+5.
//  5. Assert reset during WAIT after accepting a store @0x40.
//     -> no rsp_valid, word @0x40 reads 0 after reset, req_ready=1 immediately.
//  6. Load @ DEPTH_WORDS*4 and at width 11.
//     -> rsp_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/dm_responder.sv
// Memory-side responder for the M-stage data port: fixed-latency load/store with
// little-endian lane merging, load extension, error flagging and a store log.
module dm_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_width,
  input  logic        req_sign,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        log_valid,
  output logic [31:0] log_pc,
  output logic [31:0] log_addr,
  output logic [31:0] log_data
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [1:0]  W_WORD   = 2'b00;
  localparam logic [1:0]  W_HALF   = 2'b01;
  localparam logic [1:0]  W_BYTE   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic        req_ready_q, rsp_valid_q, rsp_err_q, log_valid_q;
  logic [31:0] rsp_rdata_q, log_pc_q, log_addr_q, log_data_q;

  logic        lat_we_q, lat_sign_q;
  logic [31:0] lat_addr_q, lat_wdata_q, lat_pc_q;
  logic [1:0]  lat_width_q;

  logic        accept, commit;
  logic        c_we, c_sign;
  logic [31:0] c_addr, c_wdata, c_pc;
  logic [1:0]  c_width;
  logic [AW-1:0] idx;
  logic [31:0] old_word, shifted;
  logic        err_d;
  logic [31:0] wr_word_d, rd_data_d;

  assign accept = req_valid && req_ready_q;
  // With LATENCY==1 the commit edge is the accept edge, so operands come straight from the request.
  assign commit = ((state_q == S_WAIT) && (cnt_q == 4'd1)) || ((LATENCY == 1) && accept);

  always_comb begin
    if (LATENCY == 1) begin
      c_we = req_we;     c_addr  = req_addr;  c_wdata = req_wdata;
      c_width = req_width; c_sign = req_sign; c_pc = req_pc;
    end else begin
      c_we = lat_we_q;     c_addr  = lat_addr_q;  c_wdata = lat_wdata_q;
      c_width = lat_width_q; c_sign = lat_sign_q; c_pc = lat_pc_q;
    end
  end

  assign idx      = c_addr[AW+1:2];
  assign old_word = mem_q[idx];
  assign shifted  = old_word >> {c_addr[1:0], 3'b000};

  always_comb begin
    err_d = 1'b0;
    if (c_width == 2'b11)                                err_d = 1'b1;
    if ((c_width == W_WORD) && (c_addr[1:0] != 2'b00))   err_d = 1'b1;
    if ((c_width == W_HALF) && c_addr[0])                err_d = 1'b1;
    if ({2'b00, c_addr[31:2]} >= DEPTH_WORDS)            err_d = 1'b1;
  end

  always_comb begin
    wr_word_d = old_word;
    rd_data_d = '0;
    case (c_width)
      W_WORD: begin
        wr_word_d = c_wdata;
        rd_data_d = old_word;
      end
      W_HALF: begin
        wr_word_d[{c_addr[1], 4'b0000} +: 16] = c_wdata[15:0];
        rd_data_d = {{16{c_sign & shifted[15]}}, shifted[15:0]};
      end
      W_BYTE: begin
        wr_word_d[{c_addr[1:0], 3'b000} +: 8] = c_wdata[7:0];
        rd_data_d = {{24{c_sign & shifted[7]}}, shifted[7:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      log_valid_q <= 1'b0;
      log_pc_q    <= '0;
      log_addr_q  <= '0;
      log_data_q  <= '0;
      lat_we_q    <= 1'b0;
      lat_sign_q  <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_pc_q    <= '0;
      lat_width_q <= '0;
      mem_q       <= '{default: '0};
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      log_valid_q <= 1'b0;
      log_pc_q    <= '0;
      log_addr_q  <= '0;
      log_data_q  <= '0;

      case (state_q)
        S_IDLE, S_RESP: begin
          if (accept) begin
            lat_we_q    <= req_we;
            lat_addr_q  <= req_addr;
            lat_wdata_q <= req_wdata;
            lat_width_q <= req_width;
            lat_sign_q  <= req_sign;
            lat_pc_q    <= req_pc;
            cnt_q       <= CNT_INIT;
            if (LATENCY == 1) begin
              state_q     <= S_RESP;
              req_ready_q <= 1'b1;
            end else begin
              state_q     <= S_WAIT;
              req_ready_q <= 1'b0;
            end
          end else begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q     <= S_RESP;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase

      if (commit) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= err_d;
        rsp_rdata_q <= (c_we || err_d) ? '0 : rd_data_d;
        if (c_we && !err_d) begin
          mem_q[idx]  <= wr_word_d;
          log_valid_q <= 1'b1;
          log_pc_q    <= c_pc;
          log_addr_q  <= {c_addr[31:2], 2'b00};
          log_data_q  <= wr_word_d;
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign log_valid = log_valid_q;
  assign log_pc    = log_pc_q;
  assign log_addr  = log_addr_q;
  assign log_data  = log_data_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: lanes, extension, errors, throughput and reset abort.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
  logic [1:0]  req_width = '0;
  logic        req_ready, rsp_valid, rsp_err, log_valid;
  logic [31:0] rsp_rdata, log_pc, log_addr, log_data;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] r_rdata, r_log_addr, r_log_data, r_log_pc;
  logic        r_err, r_log_valid;
  int unsigned r_lat;

  dm_responder #(.DEPTH_WORDS(4096), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width),
    .req_sign(req_sign), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .log_valid(log_valid), .log_pc(log_pc), .log_addr(log_addr), .log_data(log_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] width, input logic sign, input logic [31:0] pc);
    int unsigned n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_width = width; req_sign = sign; req_pc = pc;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check_eq("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) check_eq("rsp_timeout", 32'd0, 32'd1);
    r_lat = n;
    r_rdata = rsp_rdata; r_err = rsp_err; r_log_valid = log_valid;
    r_log_addr = log_addr; r_log_data = log_data; r_log_pc = log_pc;
  endtask

  logic [6:0] rdy_seq, rv_seq;
  logic [31:0] tp_rdata;
  logic        saw_rsp;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_log_valid", {31'd0, log_valid}, 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    reset = 1'b1;

    // 1: word store/load
    do_req(1'b1, 32'h10, 32'h12345678, 2'b00, 1'b0, 32'h1000);
    check_eq("t1_latency", r_lat, 32'd2);
    check_eq("t1_log_valid", {31'd0, r_log_valid}, 32'd1);
    check_eq("t1_log_addr", r_log_addr, 32'h10);
    check_eq("t1_log_data", r_log_data, 32'h12345678);
    check_eq("t1_log_pc", r_log_pc, 32'h1000);
    check_eq("t1_st_rdata", r_rdata, 32'd0);
    check_eq("t1_st_err", {31'd0, r_err}, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, 32'h1004);
    check_eq("t1_ld", r_rdata, 32'h12345678);
    check_eq("t1_ld_log_valid", {31'd0, r_log_valid}, 32'd0);

    // 2: byte store, signed/unsigned byte loads
    do_req(1'b1, 32'h21, 32'hFFFFFF80, 2'b10, 1'b0, 32'h1008);
    check_eq("t2_log_addr", r_log_addr, 32'h20);
    check_eq("t2_log_data", r_log_data, 32'h00008000);
    do_req(1'b0, 32'h21, 32'h0, 2'b10, 1'b1, 32'h100C);
    check_eq("t2_lb_signed", r_rdata, 32'hFFFFFF80);
    do_req(1'b0, 32'h21, 32'h0, 2'b10, 1'b0, 32'h1010);
    check_eq("t2_lb_unsigned", r_rdata, 32'h00000080);
    do_req(1'b0, 32'h20, 32'h0, 2'b00, 1'b0, 32'h1014);
    check_eq("t2_lw", r_rdata, 32'h00008000);

    // 3: misaligned accesses leave memory untouched; half/byte lane merges
    do_req(1'b1, 32'h00, 32'hAABBCCDD, 2'b00, 1'b0, 32'h1018);
    do_req(1'b1, 32'h03, 32'h00001234, 2'b01, 1'b0, 32'h101C);
    check_eq("t3_sh_err", {31'd0, r_err}, 32'd1);
    check_eq("t3_sh_log_valid", {31'd0, r_log_valid}, 32'd0);
    do_req(1'b0, 32'h06, 32'h0, 2'b00, 1'b0, 32'h1020);
    check_eq("t3_lw_err", {31'd0, r_err}, 32'd1);
    check_eq("t3_lw_rdata", r_rdata, 32'd0);
    do_req(1'b0, 32'h00, 32'h0, 2'b00, 1'b0, 32'h1024);
    check_eq("t3_unchanged", r_rdata, 32'hAABBCCDD);
    do_req(1'b1, 32'h02, 32'h0000BEEF, 2'b01, 1'b0, 32'h1028);
    check_eq("t3_sh_merge", r_log_data, 32'hBEEFCCDD);
    do_req(1'b1, 32'h01, 32'h00000011, 2'b10, 1'b0, 32'h102C);
    check_eq("t3_sb_merge", r_log_data, 32'hBEEF11DD);
    do_req(1'b0, 32'h02, 32'h0, 2'b01, 1'b1, 32'h1030);
    check_eq("t3_lh_signed", r_rdata, 32'hFFFFBEEF);
    do_req(1'b0, 32'h02, 32'h0, 2'b01, 1'b0, 32'h1034);
    check_eq("t3_lh_unsigned", r_rdata, 32'h0000BEEF);

    // 6: out-of-range, illegal width, last legal word
    do_req(1'b0, 32'h4000, 32'h0, 2'b00, 1'b0, 32'h1038);
    check_eq("t6_range_err", {31'd0, r_err}, 32'd1);
    check_eq("t6_range_rdata", r_rdata, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'h103C);
    check_eq("t6_w11_err", {31'd0, r_err}, 32'd1);
    check_eq("t6_w11_rdata", r_rdata, 32'd0);
    do_req(1'b1, 32'h3FFC, 32'hCAFEF00D, 2'b00, 1'b0, 32'h1040);
    check_eq("t6_last_err", {31'd0, r_err}, 32'd0);
    check_eq("t6_last_log", r_log_data, 32'hCAFEF00D);

    // 4: back-to-back requests with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_width = 2'b00; req_sign = 1'b0;
    tp_rdata = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      rdy_seq[k-1] = req_ready;
      rv_seq[k-1]  = rsp_valid;
      if (k == 2) tp_rdata = rsp_rdata;
      if (k == 5) req_valid = 1'b0;
    end
    check_eq("t4_ready_seq", {25'd0, rdy_seq}, {25'd0, 7'b1101010});
    check_eq("t4_rsp_seq", {25'd0, rv_seq}, {25'd0, 7'b0101010});
    check_eq("t4_rdata", tp_rdata, 32'h12345678);

    // 5: reset while a store is waiting
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    req_width = 2'b00;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("t5_in_wait", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("t5_ready_now", {31'd0, req_ready}, 32'd1);
    saw_rsp = rsp_valid;
    repeat (3) begin
      @(negedge clk);
      saw_rsp = saw_rsp | rsp_valid;
    end
    check_eq("t5_no_rsp", {31'd0, saw_rsp}, 32'd0);
    reset = 1'b1;
    do_req(1'b0, 32'h40, 32'h0, 2'b00, 1'b0, 32'h1044);
    check_eq("t5_word40", r_rdata, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, 32'h1048);
    check_eq("t5_word10_cleared", r_rdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
